// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - handshake, write-back and ID/EX slot signals of the issue stage
interface alu_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [4:0]      out_rd;
    logic            out_we;
    logic            out_illegal;

    modport slave (
        input  in_valid, instr, flush, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_funct3, out_funct7, out_a, out_b,
               out_rd, out_we, out_illegal
    );

    modport master (
        output in_valid, instr, flush, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_funct3, out_funct7, out_a, out_b,
               out_rd, out_we, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV64I OP/OP-IMM/LUI decode, register file and registered ID/EX slot
module alu_issue_stage #(
    parameter int XLEN      = 64,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);
    logic [XLEN-1:0] r_regs [REG_COUNT];

    logic            r_valid;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic            r_we;
    logic            r_illegal;
    // source registers of the held slot, kept so a late write-back can refresh it
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic            r_use_rs1;
    logic            r_use_rs2;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_legal;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_accept;
    logic            w_wb_hit;

    assign w_opcode = bus.instr[6:0];
    assign w_rd     = bus.instr[11:7];
    assign w_f3     = bus.instr[14:12];
    assign w_rs1    = bus.instr[19:15];
    assign w_rs2    = bus.instr[24:20];
    assign w_wb_hit = bus.wb_en && (bus.wb_rd != 5'd0);

    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

    // x0 is hard-wired; a same-cycle write-back to the source bypasses the array
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                       (w_wb_hit && bus.wb_rd == w_rs1) ? bus.wb_data : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                       (w_wb_hit && bus.wb_rd == w_rs2) ? bus.wb_data : r_regs[w_rs2];

    // decode the offered instruction into operands, ALU function and legality
    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_funct3  = '0;
        w_funct7  = '0;
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_a       = w_rs1_val;
                w_b       = w_rs2_val;
                w_funct3  = w_f3;
                w_funct7  = bus.instr[31:25];
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (bus.instr[31:25] == 7'b0000000) ||
                            (bus.instr[31:25] == 7'b0100000 &&
                             (w_f3 == 3'b000 || w_f3 == 3'b101));
            end
            7'b0010011: begin
                w_a       = w_rs1_val;
                w_funct3  = w_f3;
                w_use_rs1 = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_b     = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
                    w_legal = (bus.instr[31:26] == 6'b000000);
                end else if (w_f3 == 3'b101) begin
                    w_b      = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
                    w_funct7 = {1'b0, bus.instr[30], 5'b00000};
                    w_legal  = (bus.instr[31:26] == 6'b000000) ||
                               (bus.instr[31:26] == 6'b010000);
                end else begin
                    w_b     = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
                    w_legal = 1'b1;
                end
            end
            7'b0110111: begin
                w_b     = {{(XLEN-32){bus.instr[31]}}, bus.instr[31:12], 12'h000};
                w_legal = 1'b1;
            end
            default: ;
        endcase
        // illegal slots carry no operands and never refresh
        if (!w_legal) begin
            w_a       = '0;
            w_b       = '0;
            w_funct3  = '0;
            w_funct7  = '0;
            w_use_rs1 = 1'b0;
            w_use_rs2 = 1'b0;
        end
    end

    // register file write, then slot load / drain / flush / held-operand refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
            r_valid   <= 1'b0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_use_rs1 <= 1'b0;
            r_use_rs2 <= 1'b0;
        end else begin
            if (w_wb_hit) r_regs[bus.wb_rd] <= bus.wb_data;
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_funct3  <= w_funct3;
                r_funct7  <= w_funct7;
                r_a       <= w_a;
                r_b       <= w_b;
                r_rd      <= w_rd;
                r_we      <= w_legal && (w_rd != 5'd0);
                r_illegal <= !w_legal;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_use_rs1 <= w_use_rs1;
                r_use_rs2 <= w_use_rs2;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end else if (r_valid && w_wb_hit) begin
                if (r_use_rs1 && r_rs1 == bus.wb_rd) r_a <= bus.wb_data;
                if (r_use_rs2 && r_rs2 == bus.wb_rd) r_b <= bus.wb_data;
            end
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_funct3  = r_funct3;
    assign bus.out_funct7  = r_funct7;
    assign bus.out_a       = r_a;
    assign bus.out_b       = r_b;
    assign bus.out_rd      = r_rd;
    assign bus.out_we      = r_we;
    assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a reference decoder
module tb_alu_issue_stage;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(XLEN)) bus();
    alu_issue_stage #(.XLEN(XLEN), .REG_COUNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        s1;
        logic        s2;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mregs [32];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rdreg(logic [4:0] r, logic wen, logic [4:0] wrd, logic [63:0] wd);
        if (r == 0) return 64'd0;
        if (wen && wrd == r) return wd;
        return mregs[r];
    endfunction

    function automatic exp_t ref_dec(logic [31:0] ins, logic wen, logic [4:0] wrd, logic [63:0] wd);
        exp_t e = '{default: '0};
        bit legal = 1'b0;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        if (ins[6:0] == 7'h33) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.a = rdreg(e.rs1, wen, wrd, wd);
            e.b = rdreg(e.rs2, wen, wrd, wd);
            e.f3 = f3; e.f7 = f7; e.s1 = 1'b1; e.s2 = 1'b1;
        end else if (ins[6:0] == 7'h13) begin
            e.a = rdreg(e.rs1, wen, wrd, wd);
            e.s1 = 1'b1; e.f3 = f3;
            if (f3 == 3'd1) begin
                legal = (ins[31:26] == 6'h00);
                e.b = 64'(ins[25:20]);
            end else if (f3 == 3'd5) begin
                legal = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h10);
                e.b = 64'(ins[25:20]);
                e.f7 = ins[30] ? 7'h20 : 7'h00;
            end else begin
                legal = 1'b1;
                e.b = 64'($signed(ins[31:20]));
            end
        end else if (ins[6:0] == 7'h37) begin
            legal = 1'b1;
            e.b = 64'($signed(ins[31:12])) << 12;
        end
        if (!legal) begin
            e.a = 0; e.b = 0; e.f3 = 0; e.f7 = 0; e.s1 = 0; e.s2 = 0;
        end
        e.ill = !legal;
        e.we  = legal && (e.rd != 0);
        return e;
    endfunction

    // one clock of stimulus; the model advances after the monitor has looked at this cycle
    task automatic drive(bit r, bit iv, logic [31:0] ins, bit fl, bit wen,
                         logic [4:0] wrd, logic [63:0] wd, bit ordy);
        bit   rdy;
        bit   held;
        exp_t e;
        exp_t h;
        @(negedge clk);
        rst = r; bus.in_valid = iv; bus.instr = ins; bus.flush = fl;
        bus.wb_en = wen; bus.wb_rd = wrd; bus.wb_data = wd; bus.out_ready = ordy;
        rdy  = (q.size() == 0) || ordy;
        held = (q.size() != 0) && !ordy;
        e    = ref_dec(ins, wen, wrd, wd);
        #2;
        if (r) begin
            q.delete();
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
            return;
        end
        if (!fl && held && wen && wrd != 0 && q.size() != 0) begin
            h = q[0];
            if (h.s1 && h.rs1 == wrd) h.a = wd;
            if (h.s2 && h.rs2 == wrd) h.b = wd;
            q[0] = h;
        end
        if (!fl && iv && rdy) q.push_back(e);
        if (wen && wrd != 0) mregs[wrd] = wd;
    endtask

    task automatic idle(bit ordy);
        drive(0, 0, 32'h0, 0, 0, 5'd0, 64'd0, ordy);
    endtask

    task automatic issue(logic [31:0] ins, bit ordy);
        drive(0, 1, ins, 0, 0, 5'd0, 64'd0, ordy);
    endtask

    function automatic logic [31:0] gen();
        logic [4:0] rs1 = 5'($urandom % 8);
        logic [4:0] rs2 = 5'($urandom % 8);
        logic [4:0] rd  = 5'($urandom % 8);
        logic [2:0] f3  = 3'($urandom);
        logic [5:0] top;
        case ($urandom % 3)
            0:       top = 6'h00;
            1:       top = 6'h10;
            default: top = 6'($urandom);
        endcase
        case ($urandom % 6)
            0:       return {(($urandom % 2) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
            1:       return {7'($urandom), rs2, rs1, f3, rd, 7'h33};
            2:       return {12'($urandom), rs1, f3, rd, 7'h13};
            3:       return {top, 6'($urandom), rs1, (($urandom % 2) != 0) ? 3'd1 : 3'd5, rd, 7'h13};
            4:       return {20'($urandom), rd, 7'h37};
            default: return $urandom;
        endcase
    endfunction

    // monitor: compare the presented slot with the scoreboard head, retire on consume/flush
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("out_valid", 256'(bus.out_valid), 256'(q.size() != 0));
                chk("in_ready", 256'(bus.in_ready), 256'((q.size() == 0) || bus.out_ready));
                if (bus.out_valid && q.size() != 0) begin
                    me = q[0];
                    if (me.ill)
                        chk("slot_illegal", {bus.out_a, bus.out_b, bus.out_we, bus.out_illegal},
                            {me.a, me.b, me.we, me.ill});
                    else
                        chk("slot", {bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7,
                                     bus.out_rd, bus.out_we, bus.out_illegal},
                            {me.a, me.b, me.f3, me.f7, me.rd, me.we, me.ill});
                end
                if (q.size() != 0 && (bus.flush || bus.out_ready)) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.instr = 0; bus.flush = 0; bus.wb_en = 0;
        bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 0;
        drive(1, 0, 32'h0, 0, 0, 5'd0, 64'd0, 0);
        drive(1, 0, 32'h0, 0, 0, 5'd0, 64'd0, 0);
        chk("reset_outputs", {bus.out_valid, bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7,
                              bus.out_rd, bus.out_we, bus.out_illegal}, 256'd0);
        mon_en = 1'b1;

        // add x3,x5,x0 after x5=0x10
        drive(0, 0, 32'h0, 0, 1, 5'd5, 64'h10, 1);
        issue(32'h000281B3, 1);
        idle(1);
        chk("t1_add", {bus.out_valid, bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7, bus.out_rd, bus.out_we},
            {1'b1, 64'h10, 64'h0, 3'd0, 7'd0, 5'd3, 1'b1});

        // addi x1,x0,-1 then srai x2,x1,63
        issue(32'hFFF00093, 1);
        issue(32'h43F0D113, 1);
        chk("t2_addi_b", 256'(bus.out_b), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        idle(1);
        chk("t2_srai", {bus.out_b, bus.out_funct3, bus.out_funct7}, {64'd63, 3'd5, 7'h20});

        // held slot refreshed by a write-back to its rs1
        issue(32'h000281B3, 1);
        issue(32'hFFF00093, 0);
        drive(0, 1, 32'hFFF00093, 0, 1, 5'd5, 64'h99, 0);
        chk("t3_in_ready", 256'(bus.in_ready), 256'd0);
        idle(0);
        chk("t3_refresh", 256'(bus.out_a), 256'(64'h99));
        idle(1);

        // accept with a same-cycle write-back of both sources; x0 stays zero
        drive(0, 1, 32'h40738433, 0, 1, 5'd7, 64'h42, 1);
        idle(1);
        chk("t4_sub", {bus.out_a, bus.out_b, bus.out_funct7}, {64'h42, 64'h42, 7'h20});
        drive(0, 0, 32'h0, 0, 1, 5'd0, 64'd5, 1);
        issue(32'h000004B3, 1);
        idle(1);
        chk("t4_x0", 256'(bus.out_a), 256'd0);

        // illegal encodings
        issue(32'h00000003, 1);
        idle(1);
        chk("t5_load", {bus.out_illegal, bus.out_we}, {1'b1, 1'b0});
        issue(32'h020281B3, 1);
        idle(1);
        chk("t5_funct7", 256'(bus.out_illegal), 256'd1);

        // flush kills the held slot and the offered instruction
        issue(32'h000281B3, 0);
        drive(0, 1, 32'h000281B3, 1, 0, 5'd0, 64'd0, 0);
        idle(0);
        chk("t6_flush", 256'(bus.out_valid), 256'd0);

        // reset while stalled
        issue(32'h000281B3, 0);
        idle(0);
        drive(1, 0, 32'h0, 0, 0, 5'd0, 64'd0, 0);
        idle(0);
        chk("t6_reset", {bus.out_valid, bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7,
                         bus.out_rd, bus.out_we, bus.out_illegal}, 256'd0);
        issue(32'h000281B3, 1);
        idle(1);
        chk("t6_x5_cleared", 256'(bus.out_a), 256'd0);

        // randomized traffic against the reference decoder
        for (int n = 0; n < 400; n++) begin
            drive(0, ($urandom % 10) < 7, gen(), ($urandom % 20) == 0, ($urandom % 2) != 0,
                  5'($urandom % 8), {$urandom, $urandom}, ($urandom % 10) < 7);
        end
        idle(1);
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
